// File: rtl/issue_queue_alu.sv
// issue_queue_alu: data-capture, age-ordered, compacting issue queue feeding
// the ALU execute stage. Entries wait for both operands (captured at dispatch
// or from the result bypass bus) and the oldest ready entry issues each cycle.
module issue_queue_alu #(
   parameter int DEPTH     = 8,
   parameter int WIDTH_REG = 7,
   parameter int WIDTH_CNT = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_flush,
   input  logic                     i_dis_valid,
   input  logic [6:0]               i_dis_uop,
   input  logic [9:0]               i_dis_func,
   input  logic [WIDTH_REG-1:0]     i_dis_rd,
   input  logic [31:0]              i_dis_PC,
   input  logic [31:0]              i_dis_imm,
   input  logic [WIDTH_REG-1:0]     i_dis_rs1,
   input  logic [WIDTH_REG-1:0]     i_dis_rs2,
   input  logic                     i_dis_rdy1,
   input  logic                     i_dis_rdy2,
   input  logic [31:0]              i_dis_op1,
   input  logic [31:0]              i_dis_op2,
   input  logic [32+WIDTH_REG:0]    i_bypass,
   output logic                     o_full,
   output logic [WIDTH_CNT-1:0]     o_count,
   output logic                     o_valid,
   output logic [6:0]               o_uop,
   output logic [9:0]               o_func,
   output logic [WIDTH_REG-1:0]     o_addr,
   output logic [31:0]              o_PC,
   output logic [31:0]              o_op1,
   output logic [31:0]              o_op2,
   output logic [31:0]              o_imm
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef struct packed {
      logic                 valid;
      logic [6:0]           uop;
      logic [9:0]           func;
      logic [WIDTH_REG-1:0] rd;
      logic [31:0]          pc;
      logic [31:0]          imm;
      logic [WIDTH_REG-1:0] rs1;
      logic [WIDTH_REG-1:0] rs2;
      logic                 rdy1;
      logic                 rdy2;
      logic [31:0]          op1;
      logic [31:0]          op2;
   } entry_t;

   entry_t [DEPTH-1:0]   q;
   entry_t [DEPTH-1:0]   q_nxt;
   // One extra empty slot on top so the shift-down of the youngest entry
   // pulls in an invalid entry.
   entry_t [DEPTH:0]     woken;
   entry_t               new_entry;
   logic [WIDTH_CNT-1:0] count;
   logic [WIDTH_CNT-1:0] count_nxt;
   logic [WIDTH_CNT-1:0] wr_idx;
   logic [IDX_W-1:0]     sel;
   logic                 issue;
   logic                 accept;
   logic                 byp_valid;
   logic [WIDTH_REG-1:0] byp_tag;
   logic [31:0]          byp_data;

   assign byp_valid = i_bypass[32+WIDTH_REG];
   assign byp_tag   = i_bypass[31+WIDTH_REG:32];
   assign byp_data  = i_bypass[31:0];

   assign o_full  = (count == WIDTH_CNT'(DEPTH));
   assign o_count = count;
   assign accept  = i_dis_valid & ~o_full & ~i_flush;
   // Slot for the new entry: one lower when the issuing entry vacates a slot.
   assign wr_idx  = count - WIDTH_CNT'(issue);

   // Select the oldest entry whose registered operands are both ready.
   always_comb begin
      issue = 1'b0;
      sel   = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (q[i].valid && q[i].rdy1 && q[i].rdy2) begin
            issue = 1'b1;
            sel   = IDX_W'(i);
         end else begin
            issue = issue;
            sel   = sel;
         end
      end
   end

   // Apply bypass wakeup to the stored entries before any shifting.
   always_comb begin
      woken = '0;
      for (int i = 0; i < DEPTH; i++) begin
         woken[i] = q[i];
         if (byp_valid && q[i].valid && !q[i].rdy1 && (q[i].rs1 == byp_tag)) begin
            woken[i].rdy1 = 1'b1;
            woken[i].op1  = byp_data;
         end else begin
            woken[i].rdy1 = q[i].rdy1;
         end
         if (byp_valid && q[i].valid && !q[i].rdy2 && (q[i].rs2 == byp_tag)) begin
            woken[i].rdy2 = 1'b1;
            woken[i].op2  = byp_data;
         end else begin
            woken[i].rdy2 = q[i].rdy2;
         end
      end
   end

   // Build the incoming entry, capturing a same-cycle bypass result.
   always_comb begin
      new_entry       = '0;
      new_entry.valid = 1'b1;
      new_entry.uop   = i_dis_uop;
      new_entry.func  = i_dis_func;
      new_entry.rd    = i_dis_rd;
      new_entry.pc    = i_dis_PC;
      new_entry.imm   = i_dis_imm;
      new_entry.rs1   = i_dis_rs1;
      new_entry.rs2   = i_dis_rs2;
      new_entry.rdy1  = i_dis_rdy1 | (byp_valid & (i_dis_rs1 == byp_tag));
      new_entry.rdy2  = i_dis_rdy2 | (byp_valid & (i_dis_rs2 == byp_tag));
      new_entry.op1   = i_dis_rdy1 ? i_dis_op1 : byp_data;
      new_entry.op2   = i_dis_rdy2 ? i_dis_op2 : byp_data;
   end

   // Next queue image: compact over the issued slot, then insert dispatch.
   always_comb begin
      q_nxt     = '0;
      count_nxt = count;
      if (i_flush) begin
         q_nxt     = '0;
         count_nxt = '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (accept && (WIDTH_CNT'(i) == wr_idx)) begin
               q_nxt[i] = new_entry;
            end else if (issue && (IDX_W'(i) >= sel)) begin
               q_nxt[i] = woken[i+1];
            end else begin
               q_nxt[i] = woken[i];
            end
         end
         count_nxt = count + WIDTH_CNT'(accept) - WIDTH_CNT'(issue);
      end
   end

   // Drive the execute bundle from the selected entry, zero when idle.
   always_comb begin
      o_valid = issue;
      if (issue) begin
         o_uop  = q[sel].uop;
         o_func = q[sel].func;
         o_addr = q[sel].rd;
         o_PC   = q[sel].pc;
         o_op1  = q[sel].op1;
         o_op2  = q[sel].op2;
         o_imm  = q[sel].imm;
      end else begin
         o_uop  = 7'd0;
         o_func = 10'd0;
         o_addr = '0;
         o_PC   = 32'd0;
         o_op1  = 32'd0;
         o_op2  = 32'd0;
         o_imm  = 32'd0;
      end
   end

   // Queue state and occupancy register with asynchronous reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         q     <= '0;
         count <= '0;
      end else begin
         q     <= q_nxt;
         count <= count_nxt;
      end
   end

endmodule

// File: tb/tb_issue_queue_alu.sv
// Scoreboard bench for issue_queue_alu: directed stimulus pushes expected
// issue records; a negedge monitor pops and compares every issued op.
module tb_issue_queue_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        dis_valid;
   logic [6:0]  dis_uop;
   logic [9:0]  dis_func;
   logic [6:0]  dis_rd;
   logic [31:0] dis_pc;
   logic [31:0] dis_imm;
   logic [6:0]  dis_rs1;
   logic [6:0]  dis_rs2;
   logic        dis_rdy1;
   logic        dis_rdy2;
   logic [31:0] dis_op1;
   logic [31:0] dis_op2;
   logic [39:0] bypass;
   logic        o_full;
   logic [3:0]  o_count;
   logic        o_valid;
   logic [6:0]  o_uop;
   logic [9:0]  o_func;
   logic [6:0]  o_addr;
   logic [31:0] o_PC;
   logic [31:0] o_op1;
   logic [31:0] o_op2;
   logic [31:0] o_imm;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [6:0]  uop;
      logic [9:0]  func;
      logic [6:0]  addr;
      logic [31:0] pc;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] imm;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;

   issue_queue_alu #(.DEPTH(8), .WIDTH_REG(7), .WIDTH_CNT(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush),
      .i_dis_valid(dis_valid), .i_dis_uop(dis_uop), .i_dis_func(dis_func),
      .i_dis_rd(dis_rd), .i_dis_PC(dis_pc), .i_dis_imm(dis_imm),
      .i_dis_rs1(dis_rs1), .i_dis_rs2(dis_rs2),
      .i_dis_rdy1(dis_rdy1), .i_dis_rdy2(dis_rdy2),
      .i_dis_op1(dis_op1), .i_dis_op2(dis_op2), .i_bypass(bypass),
      .o_full(o_full), .o_count(o_count), .o_valid(o_valid),
      .o_uop(o_uop), .o_func(o_func), .o_addr(o_addr), .o_PC(o_PC),
      .o_op1(o_op1), .o_op2(o_op2), .o_imm(o_imm)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dis_valid = 1'b0;
      flush     = 1'b0;
      bypass    = 40'd0;
   endtask

   task automatic drive(input logic [6:0] uop, input logic [9:0] func,
                        input logic [6:0] rd, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [6:0] rs1,
                        input logic [6:0] rs2, input logic r1, input logic r2,
                        input logic [31:0] op1, input logic [31:0] op2);
      dis_valid = 1'b1;
      dis_uop   = uop;
      dis_func  = func;
      dis_rd    = rd;
      dis_pc    = pc;
      dis_imm   = imm;
      dis_rs1   = rs1;
      dis_rs2   = rs2;
      dis_rdy1  = r1;
      dis_rdy2  = r2;
      dis_op1   = op1;
      dis_op2   = op2;
   endtask

   task automatic expect_issue(input logic [6:0] uop, input logic [9:0] func,
                               input logic [6:0] rd, input logic [31:0] pc,
                               input logic [31:0] op1, input logic [31:0] op2,
                               input logic [31:0] imm);
      exp_t x;
      x.uop = uop; x.func = func; x.addr = rd; x.pc = pc;
      x.op1 = op1; x.op2 = op2; x.imm = imm;
      sb.push_back(x);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every issued op must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         if (o_valid) begin
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_issue: got rd=%0d pc=0x%0h, expected no issue", o_addr, o_PC);
            end else begin
               e = sb.pop_front();
               if (o_uop !== e.uop || o_func !== e.func || o_addr !== e.addr || o_PC !== e.pc ||
                   o_op1 !== e.op1 || o_op2 !== e.op2 || o_imm !== e.imm) begin
                  errors++;
                  $display("FAIL issue: got uop=%0h func=%0h rd=%0d pc=%0h op1=%0h op2=%0h imm=%0h expected uop=%0h func=%0h rd=%0d pc=%0h op1=%0h op2=%0h imm=%0h",
                           o_uop, o_func, o_addr, o_PC, o_op1, o_op2, o_imm,
                           e.uop, e.func, e.addr, e.pc, e.op1, e.op2, e.imm);
               end
            end
         end else if ({o_uop, o_func, o_addr, o_PC, o_op1, o_op2, o_imm} !== '0) begin
            errors++;
            $display("FAIL idle_zero: got nonzero data with o_valid=0, expected all zero");
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      idle();
      drive(7'd0, 10'd0, 7'd0, 32'd0, 32'd0, 7'd0, 7'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      dis_valid = 1'b0;
      #2;
      check("reset_valid", {31'd0, o_valid}, 32'd0);
      check("reset_count", {28'd0, o_count}, 32'd0);
      check("reset_full", {31'd0, o_full}, 32'd0);
      check("reset_data", {31'd0, |{o_uop, o_func, o_addr, o_PC, o_op1, o_op2, o_imm}}, 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // Single ready ADD issues the cycle after dispatch.
      expect_issue(OP_R, 10'd0, 7'd5, 32'h100, 32'd3, 32'd4, 32'd0);
      drive(OP_R, 10'd0, 7'd5, 32'h100, 32'd0, 7'd1, 7'd2, 1'b1, 1'b1, 32'd3, 32'd4);
      tick();
      idle();
      check("add_count_1", {28'd0, o_count}, 32'd1);
      check("add_valid", {31'd0, o_valid}, 32'd1);
      tick();
      check("add_count_0", {28'd0, o_count}, 32'd0);

      // Younger ready op B issues ahead of older A waiting on tag 9.
      expect_issue(OP_R, 10'd0, 7'd7, 32'h204, 32'd10, 32'd20, 32'd0);
      expect_issue(OP_R, 10'h100, 7'd6, 32'h200, 32'h55, 32'd1, 32'd0);
      drive(OP_R, 10'h100, 7'd6, 32'h200, 32'd0, 7'd9, 7'd0, 1'b0, 1'b1, 32'd0, 32'd1);
      tick();
      drive(OP_R, 10'd0, 7'd7, 32'h204, 32'd0, 7'd1, 7'd2, 1'b1, 1'b1, 32'd10, 32'd20);
      tick();
      idle();
      bypass = {1'b1, 7'd9, 32'h55};
      tick();
      bypass = 40'd0;
      tick();
      check("wake_count_0", {28'd0, o_count}, 32'd0);

      // Dispatch-time capture of a same-cycle bypass on rs2.
      expect_issue(OP_R, 10'd0, 7'd8, 32'h300, 32'h11, 32'hAA, 32'd0);
      drive(OP_R, 10'd0, 7'd8, 32'h300, 32'd0, 7'd3, 7'd12, 1'b1, 1'b0, 32'h11, 32'hDEAD);
      bypass = {1'b1, 7'd12, 32'hAA};
      tick();
      idle();
      tick();
      check("capture_count_0", {28'd0, o_count}, 32'd0);

      // Fill all entries with waiting ops, then wake them in age order.
      for (int i = 0; i < 8; i++) begin
         expect_issue(OP_I, 10'd0, 7'(10 + i), 32'h400 + 32'(4 * i), 32'(i), 32'(8'h30 + i), 32'(8'h30 + i));
         drive(OP_I, 10'd0, 7'(10 + i), 32'h400 + 32'(4 * i), 32'(8'h30 + i), 7'(20 + i), 7'd0,
               1'b0, 1'b1, 32'd0, 32'(8'h30 + i));
         tick();
      end
      check("fill_full", {31'd0, o_full}, 32'd1);
      check("fill_count", {28'd0, o_count}, 32'd8);
      drive(OP_R, 10'd0, 7'd99, 32'h500, 32'd0, 7'd1, 7'd2, 1'b1, 1'b1, 32'd1, 32'd2);
      tick();
      check("ninth_refused", {28'd0, o_count}, 32'd8);
      for (int i = 0; i < 8; i++) begin
         bypass = {1'b1, 7'(20 + i), 32'(i)};
         if (i == 1) begin
            drive(OP_R, 10'd0, 7'd98, 32'h504, 32'd0, 7'd1, 7'd2, 1'b1, 1'b1, 32'd1, 32'd2);
         end else begin
            dis_valid = 1'b0;
         end
         tick();
         check("drain_count", {28'd0, o_count}, 32'(8 - i));
      end
      idle();
      tick();
      check("drain_count_end", {28'd0, o_count}, 32'd0);
      check("drain_full_end", {31'd0, o_full}, 32'd0);

      // Three entries woken together issue oldest first; a dispatch alongside
      // the first issue lands behind the remaining two.
      for (int k = 0; k < 3; k++) begin
         expect_issue(OP_R, 10'd0, 7'(30 + k), 32'h600 + 32'(4 * k), 32'h77, 32'(k), 32'd0);
      end
      expect_issue(OP_R, 10'd0, 7'd33, 32'h60C, 32'd1, 32'd2, 32'd0);
      for (int k = 0; k < 3; k++) begin
         drive(OP_R, 10'd0, 7'(30 + k), 32'h600 + 32'(4 * k), 32'd0, 7'd40, 7'd0,
               1'b0, 1'b1, 32'd0, 32'(k));
         tick();
      end
      idle();
      bypass = {1'b1, 7'd40, 32'h77};
      tick();
      bypass = 40'd0;
      drive(OP_R, 10'd0, 7'd33, 32'h60C, 32'd0, 7'd1, 7'd2, 1'b1, 1'b1, 32'd1, 32'd2);
      tick();
      idle();
      check("order_count", {28'd0, o_count}, 32'd3);
      tick();
      tick();
      tick();
      check("order_count_0", {28'd0, o_count}, 32'd0);

      // Flush together with dispatch empties the queue and drops the op.
      for (int k = 0; k < 4; k++) begin
         drive(OP_R, 10'd0, 7'(40 + k), 32'h700 + 32'(4 * k), 32'd0, 7'd50, 7'd0,
               1'b0, 1'b1, 32'd0, 32'd0);
         tick();
      end
      idle();
      check("preflush_count", {28'd0, o_count}, 32'd4);
      drive(OP_R, 10'd0, 7'd77, 32'h710, 32'd0, 7'd1, 7'd2, 1'b1, 1'b1, 32'd1, 32'd2);
      flush = 1'b1;
      tick();
      idle();
      check("flush_count", {28'd0, o_count}, 32'd0);
      check("flush_valid", {31'd0, o_valid}, 32'd0);
      bypass = {1'b1, 7'd50, 32'd1};
      tick();
      bypass = 40'd0;
      tick();
      check("flush_stays_empty", {28'd0, o_count}, 32'd0);

      // Asynchronous reset mid-cycle clears outputs immediately.
      expect_issue(OP_R, 10'd0, 7'd60, 32'h800, 32'd5, 32'd6, 32'd0);
      drive(OP_R, 10'd0, 7'd60, 32'h800, 32'd0, 7'd1, 7'd2, 1'b1, 1'b1, 32'd5, 32'd6);
      tick();
      drive(OP_R, 10'd0, 7'd61, 32'h804, 32'd0, 7'd1, 7'd2, 1'b1, 1'b1, 32'd7, 32'd8);
      tick();
      idle();
      check("prereset_valid", {31'd0, o_valid}, 32'd1);
      check("prereset_addr", {25'd0, o_addr}, 32'd61);
      #1;
      rst = 1'b1;
      #1;
      check("async_valid", {31'd0, o_valid}, 32'd0);
      check("async_count", {28'd0, o_count}, 32'd0);
      check("async_full", {31'd0, o_full}, 32'd0);
      check("async_data", {31'd0, |{o_uop, o_func, o_addr, o_PC, o_op1, o_op2, o_imm}}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
